// File: rtl/p_ram_dp.sv
// Dual-port RAM, 1 write + 1 registered read, with a zeroing sweep after reset or clear; P_RAM_DP_BYPASS_EN selects write-first.
// Latency: read data on out one cycle after an accepted rd_en; a sweep takes 2**SEL_WIDTH cycles.
// Backpressure: none; load/rd_en/clear are dropped while busy, and a clear drops same-cycle load/rd_en.
module p_ram_dp #(
  parameter int BIT_WIDTH = 16,
  parameter int SEL_WIDTH = 3
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [BIT_WIDTH-1:0] in,
  input  logic [SEL_WIDTH-1:0] wr_address,
  input  logic                 load,
  input  logic [SEL_WIDTH-1:0] rd_address,
  input  logic                 rd_en,
  input  logic                 clear,
  output logic [BIT_WIDTH-1:0] out,
  output logic                 out_valid,
  output logic                 busy
);

  localparam int DEPTH = 1 << SEL_WIDTH;

  typedef enum logic {
    ST_SWEEP = 1'b0,
    ST_IDLE  = 1'b1
  } state_t;

  state_t               state, state_nxt;
  logic [SEL_WIDTH-1:0] sweep_ptr, ptr_nxt;
  logic [BIT_WIDTH-1:0] mem [DEPTH];

  logic                 wr_acc, rd_acc;
  logic                 mem_we;
  logic [SEL_WIDTH-1:0] mem_wa;
  logic [BIT_WIDTH-1:0] mem_wd;
  logic [BIT_WIDTH-1:0] rd_dat;

  always_comb begin
    state_nxt = state;
    ptr_nxt   = sweep_ptr;
    wr_acc    = 1'b0;
    rd_acc    = 1'b0;
    case (state)
      ST_SWEEP: begin
        ptr_nxt = sweep_ptr + SEL_WIDTH'(1);
        if (sweep_ptr == '1) state_nxt = ST_IDLE;
      end
      ST_IDLE: begin
        if (clear) begin
          state_nxt = ST_SWEEP;
          ptr_nxt   = '0;
        end else begin
          wr_acc = load;
          rd_acc = rd_en;
        end
      end
    endcase
  end

  // The sweep borrows the single write port; user writes only land when idle.
  assign mem_we = (state == ST_SWEEP) || wr_acc;
  assign mem_wa = (state == ST_SWEEP) ? sweep_ptr : wr_address;
  assign mem_wd = (state == ST_SWEEP) ? '0 : in;

  always_ff @(posedge clock) begin
    if (mem_we && !reset) mem[mem_wa] <= mem_wd;
  end

`ifdef P_RAM_DP_BYPASS_EN
  assign rd_dat = (wr_acc && (wr_address == rd_address)) ? in : mem[rd_address];
`else
  assign rd_dat = mem[rd_address];
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= ST_SWEEP;
      sweep_ptr <= '0;
      out       <= '0;
      out_valid <= 1'b0;
    end else begin
      state     <= state_nxt;
      sweep_ptr <= ptr_nxt;
      out_valid <= rd_acc;
      if (rd_acc) out <= rd_dat;
    end
  end

  assign busy = (state == ST_SWEEP);

endmodule

// File: tb/tb_p_ram_dp.sv
// Randomised and directed checks of p_ram_dp against a word-array reference model.
module tb_p_ram_dp;
  localparam int BW    = 16;
  localparam int SW    = 3;
  localparam int DEPTH = 1 << SW;
`ifdef P_RAM_DP_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic [BW-1:0] din;
  logic [SW-1:0] wa, ra;
  logic          load, rd_en, clear;
  logic [BW-1:0] dout;
  logic          out_valid, busy;

  p_ram_dp #(.BIT_WIDTH(BW), .SEL_WIDTH(SW)) dut (
    .clock(clock), .reset(reset), .in(din), .wr_address(wa), .load(load),
    .rd_address(ra), .rd_en(rd_en), .clear(clear), .out(dout),
    .out_valid(out_valid), .busy(busy)
  );

  always #5 clock = ~clock;

  logic [BW-1:0] m_mem [DEPTH];
  int            sweep_left;
  logic [BW-1:0] m_out;
  logic          m_vld;
  int            n_cmp = 0;
  int            n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle_in();
    load = 1'b0; rd_en = 1'b0; clear = 1'b0;
    din = '0; wa = '0; ra = '0;
  endtask

  task automatic model_zero();
    for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
  endtask

  // One clock: the model consumes the inputs at the edge, outputs are compared at the next falling edge.
  task automatic step(input string tag);
    @(posedge clock);
    if (sweep_left > 0) begin
      sweep_left--;
      m_vld = 1'b0;
    end else if (clear) begin
      sweep_left = DEPTH;
      model_zero();
      m_vld = 1'b0;
    end else begin
      if (rd_en) begin
        m_out = (BYP && load && (wa == ra)) ? din : m_mem[ra];
        m_vld = 1'b1;
      end else begin
        m_vld = 1'b0;
      end
      if (load) m_mem[wa] = din;
    end
    @(negedge clock);
    chk({tag, ".busy"},  {31'd0, busy},      {31'd0, sweep_left > 0});
    chk({tag, ".valid"}, {31'd0, out_valid}, {31'd0, m_vld});
    chk({tag, ".out"},   {16'd0, dout},      {16'd0, m_out});
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b1;
    idle_in();
    #12;
    chk({tag, ".rst_busy"},  {31'd0, busy},      32'd1);
    chk({tag, ".rst_valid"}, {31'd0, out_valid}, 32'd0);
    chk({tag, ".rst_out"},   {16'd0, dout},      32'd0);
    @(negedge clock);
    reset      = 1'b0;
    sweep_left = DEPTH;
    model_zero();
    m_out = '0;
    m_vld = 1'b0;
  endtask

  // Counts busy cycles until idle, bounded so a stuck sweep still reaches the summary.
  task automatic sweep_len(input string tag, input int exp_len);
    int n;
    n = 0;
    while (busy && n < 4 * DEPTH) begin
      step(tag);
      n++;
    end
    chk({tag, ".busy_len"}, n, exp_len);
  endtask

  initial begin
    idle_in();
    sweep_left = DEPTH;
    model_zero();
    m_out = '0;
    m_vld = 1'b0;

    do_reset("por");
    sweep_len("por_sweep", DEPTH);

    load = 1'b1; wa = 3'd5; din = 16'hBEEF;
    step("wr5");
    idle_in(); rd_en = 1'b1; ra = 3'd5;
    step("rd5");
    chk("rd5_val", {16'd0, dout}, 32'hBEEF);
    idle_in();
    step("rd5_idle");
    chk("rd5_hold_v", {31'd0, out_valid}, 32'd0);
    chk("rd5_hold_o", {16'd0, dout}, 32'hBEEF);

    load = 1'b1; wa = 3'd2; din = 16'h1111;
    step("wr2");
    load = 1'b1; wa = 3'd2; din = 16'h2222; rd_en = 1'b1; ra = 3'd2;
    step("rw2");
    chk("rw2_val", {16'd0, dout}, BYP ? 32'h2222 : 32'h1111);
    idle_in(); rd_en = 1'b1; ra = 3'd2;
    step("rd2");
    chk("rd2_val", {16'd0, dout}, 32'h2222);

    for (int i = 0; i < DEPTH; i++) begin
      idle_in(); load = 1'b1; wa = SW'(i); din = BW'(16'h0100 + i);
      step("fill");
    end
    idle_in(); clear = 1'b1; load = 1'b1; wa = 3'd1; din = 16'hAAAA;
    step("clr");
    idle_in();
    sweep_len("clr_sweep", DEPTH);
    for (int i = 0; i < DEPTH; i++) begin
      idle_in(); rd_en = 1'b1; ra = SW'(i);
      step("clr_rd");
      chk("clr_rd_zero", {16'd0, dout}, 32'd0);
    end

    idle_in(); clear = 1'b1;
    step("clr2");
    idle_in();
    for (int i = 0; i < 3; i++) step("mid_sweep");
    do_reset("mid_rst");
    sweep_len("mid_rst_sweep", DEPTH);

    idle_in(); clear = 1'b1;
    step("clr3");
    idle_in(); load = 1'b1; wa = 3'd3; din = 16'h5555; rd_en = 1'b1; ra = 3'd3;
    step("busy_rw");
    chk("busy_rw_valid", {31'd0, out_valid}, 32'd0);
    idle_in();
    sweep_len("busy_rest", DEPTH - 1);
    rd_en = 1'b1; ra = 3'd3;
    step("rd3");
    chk("rd3_zero", {16'd0, dout}, 32'd0);

    for (int i = 0; i < 800; i++) begin
      load  = ($urandom_range(0, 1) == 1);
      rd_en = ($urandom_range(0, 1) == 1);
      clear = ($urandom_range(0, 39) == 0);
      din   = BW'($urandom);
      wa    = SW'($urandom);
      ra    = ($urandom_range(0, 3) == 0) ? wa : SW'($urandom);
      step("rand");
    end
    idle_in();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/p_ram_dp.md
P_RAM_DP -- requirements
Module: p_ram_dp

Interface
REQ-001 The block SHALL provide parameter BIT_WIDTH, default 16: data word width in bits (>= 1).
REQ-002 The block SHALL provide parameter SEL_WIDTH, default 3: address width; depth = 2**SEL_WIDTH words (>= 1).
REQ-003 The block SHALL have one clock and an asynchronous, active-high reset, on the ports below.
REQ-004 Port clock, input, 1 bit: sole clock; all state updates on its rising edge.
REQ-005 Port reset, input, 1 bit: asynchronous, active-high reset.
REQ-006 Port in, input, BIT_WIDTH bits: write data.
REQ-007 Port wr_address, input, SEL_WIDTH bits: write address.
REQ-008 Port load, input, 1 bit: write enable.
REQ-009 Port rd_address, input, SEL_WIDTH bits: read address.
REQ-010 Port rd_en, input, 1 bit: read request.
REQ-011 Port clear, input, 1 bit: request to zero the whole memory.
REQ-012 Port out, output, BIT_WIDTH bits: registered read data.
REQ-013 Port out_valid, output, 1 bit: out carries data from a read accepted in the previous cycle.
REQ-014 Port busy, output, 1 bit: clear sweep in progress; load and rd_en are ignored.

Function
REQ-015 The block SHALL hold a control FSM with two states: SWEEP (busy=1) and IDLE (busy=0).
REQ-016 In SWEEP, the block SHALL write 0 to the address held in sweep_ptr on each cycle, then increment sweep_ptr.
REQ-017 In SWEEP, when sweep_ptr = 2**SEL_WIDTH-1, the block SHALL write 0 to that address, wrap sweep_ptr to 0, and enter IDLE on the next cycle; a full sweep SHALL take exactly 2**SEL_WIDTH cycles.
REQ-018 In IDLE with clear=1, the block SHALL enter SWEEP with sweep_ptr=0, drop any load or rd_en issued that cycle, and force out_valid=0 on the next cycle.
REQ-019 In IDLE with load=1 and clear=0, the block SHALL write in to mem[wr_address] at the clock edge.
REQ-020 In IDLE with rd_en=1 and clear=0, the block SHALL load mem[rd_address] into out and set out_valid=1 on the next edge (latency 1).
REQ-021 On any cycle without an accepted read, the block SHALL clear out_valid to 0 and SHALL hold out at its previous value.
REQ-022 In SWEEP, the block SHALL ignore load, rd_en and clear; out_valid SHALL stay 0 and out SHALL hold its value.
REQ-023 Simultaneous writes and reads to different addresses SHALL both complete in the same cycle.
REQ-024 For a simultaneous write and read to the same address, the value returned SHALL be set by the configuration in REQ-030.

Reset
REQ-025 While reset=1, the block SHALL set out=0 and out_valid=0, and SHALL hold sweep_ptr=0, state=SWEEP and busy=1, independent of clock.
REQ-026 After reset deasserts, the block SHALL run a full sweep (REQ-016 to REQ-017) before becoming IDLE.
REQ-027 Reset asserted mid-sweep or mid-read SHALL abort the operation, and the sweep SHALL restart from address 0 after deassertion.
REQ-028 Memory contents SHALL NOT be reset asynchronously; zeroing SHALL occur only through the sweep.

Configuration
REQ-029 The block SHALL support one compile-time macro, P_RAM_DP_BYPASS_EN.
REQ-030 With P_RAM_DP_BYPASS_EN defined, a same-cycle load and rd_en to the same address SHALL return the new in value (write-first).
REQ-031 Without P_RAM_DP_BYPASS_EN, a same-cycle load and rd_en to the same address SHALL return the previous stored value (read-first), and no forwarding logic SHALL be synthesised.

Verification
REQ-032 The bench SHALL cover: reset pulse, release -> busy=1 for exactly 8 cycles, then 0; out=0, out_valid=0 throughout.
REQ-033 The bench SHALL cover: write 0xBEEF @5, next cycle rd_en @5 -> out=0xBEEF and out_valid=1 one cycle later; next idle cycle -> out_valid=0, out still 0xBEEF.
REQ-034 The bench SHALL cover: mem[2]=0x1111, same-cycle load 0x2222 @2 with rd_en @2 -> out=0x2222 with P_RAM_DP_BYPASS_EN, 0x1111 without; a later read @2 -> 0x2222 in both.
REQ-035 The bench SHALL cover: all addresses written non-zero, clear pulse in the same cycle as load 0xAAAA @1 -> 8 busy cycles, then every read returns 0, including @1.
REQ-036 The bench SHALL cover: reset asserted on sweep cycle 4 -> after release, busy=1 for a full 8 cycles again.
REQ-037 The bench SHALL cover: during busy, load 0x5555 @3 and rd_en @3 -> out_valid stays 0, and a read @3 after busy drops returns 0.
